// File: rtl/mb_cycle_sequencer.sv
// mb_cycle_sequencer
//   Motherboard-side cycle sequencer. Generates the E clock, runs MC6800
//   VPA/VMA cycles and produces programmable wait-state /DTACK for NUM_CH
//   internal slow windows. Everything runs on MB_CLK; /AS, /VPA and /DTACK
//   are double-flop synchronised. CYCLE_DTACK is ANDed with the other DTACK
//   terms at top level.
//
//   Optional feature: define BUS_TIMEOUT_EN to enable the bus-error timeout.
//   Without it BERR_N is tied high.
//
// Ports
//   RESET        in   async active-low reset
//   MB_CLK       in   motherboard clock
//   CPU_AS       in   CPU /AS (asynchronous, active-low)
//   CPU_FC       in   CPU function code, 3'b111 = CPU space
//   MB_VPA       in   motherboard /VPA, active-low
//   MB_DTACK     in   motherboard /DTACK, active-low (timeout only)
//   CH_SEL       in   per-channel window hits, bit 0 highest priority
//   CH_WAIT      in   per-channel wait counts, WAIT_W bits each
//   E_CLK        out  E clock
//   MB_VMA       out  /VMA, active-low
//   CYCLE_DTACK  out  /DTACK contribution, active-low
//   BUSY         out  FSM not in IDLE
//   BERR_N       out  /BERR, active-low
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for an unserved /AS; decodes channel hit or VPA
// S_WAIT    | counting down the selected channel's wait states
// S_VPA_SYNC| 6800 cycle pending, waiting for e_cnt == VMA_POINT
// S_VPA_E   | /VMA asserted, waiting for e_cnt == E_FALL-1 to give DTACK
// S_HOLD    | DTACK asserted until /AS is released
module mb_cycle_sequencer #(
  parameter int E_DIV       = 10,
  parameter int E_RISE      = 4,
  parameter int E_FALL      = 8,
  parameter int VMA_POINT   = 2,
  parameter int NUM_CH      = 3,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     RESET,
  input  logic                     MB_CLK,
  input  logic                     CPU_AS,
  input  logic [2:0]               CPU_FC,
  input  logic                     MB_VPA,
  input  logic                     MB_DTACK,
  input  logic [NUM_CH-1:0]        CH_SEL,
  input  logic [NUM_CH*WAIT_W-1:0] CH_WAIT,
  output logic                     E_CLK,
  output logic                     MB_VMA,
  output logic                     CYCLE_DTACK,
  output logic                     BUSY,
  output logic                     BERR_N
);

  localparam int EW = (E_DIV > 1) ? $clog2(E_DIV) : 1;
  localparam logic [EW-1:0] E_LAST_C  = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_RISE_C  = EW'(E_RISE);
  localparam logic [EW-1:0] E_FALL_C  = EW'(E_FALL);
  localparam logic [EW-1:0] E_FALLM_C = EW'(E_FALL - 1);
  localparam logic [EW-1:0] VMA_C     = EW'(VMA_POINT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_VPA_SYNC, S_VPA_E, S_HOLD
  } state_t;

  state_t              state, state_nxt;
  logic [EW-1:0]       e_cnt;
  logic                e_clk_q;
  logic [1:0]          as_sync, vpa_sync, dtack_sync;
  logic                as_s, vpa_s;
  logic [WAIT_W-1:0]   wcnt, wcnt_nxt, sel_wait;
  logic                served, served_nxt;
  logic                dtack_q, dtack_nxt, vma_q, vma_nxt;
  logic                preset_n;

  assign as_s  = as_sync[1];
  assign vpa_s = vpa_sync[1];

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      as_sync    <= 2'b11;
      vpa_sync   <= 2'b11;
      dtack_sync <= 2'b11;
    end else begin
      as_sync    <= {as_sync[0], CPU_AS};
      vpa_sync   <= {vpa_sync[0], MB_VPA};
      dtack_sync <= {dtack_sync[0], MB_DTACK};
    end
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      e_cnt   <= '0;
      e_clk_q <= 1'b0;
    end else begin
      e_cnt <= (e_cnt == E_LAST_C) ? '0 : e_cnt + 1'b1;
      if (e_cnt == E_RISE_C)
        e_clk_q <= 1'b1;
      else if (e_cnt == E_FALL_C)
        e_clk_q <= 1'b0;
    end
  end

  // Lowest-index selected channel wins: it is assigned last.
  always_comb begin
    sel_wait = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (CH_SEL[i]) sel_wait = CH_WAIT[i*WAIT_W +: WAIT_W];
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      served <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      served <= served_nxt;
    end
  end

  // /AS high presets DTACK and VMA directly so the CPU sees them released
  // without waiting for the synchroniser.
  assign preset_n = RESET & ~CPU_AS;

  always_ff @(posedge MB_CLK or negedge preset_n) begin
    if (!preset_n) begin
      dtack_q <= 1'b1;
      vma_q   <= 1'b1;
    end else begin
      dtack_q <= dtack_nxt;
      vma_q   <= vma_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    served_nxt = served;
    dtack_nxt  = dtack_q;
    vma_nxt    = vma_q;
    if (as_s) begin
      state_nxt  = S_IDLE;
      wcnt_nxt   = '0;
      served_nxt = 1'b0;
      dtack_nxt  = 1'b1;
      vma_nxt    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dtack_nxt = 1'b1;
          vma_nxt   = 1'b1;
          if (!served) begin
            if (|CH_SEL) begin
              wcnt_nxt   = sel_wait;
              served_nxt = 1'b1;
              state_nxt  = S_WAIT;
            end else if (!vpa_s && CPU_FC != 3'b111) begin
              served_nxt = 1'b1;
              state_nxt  = S_VPA_SYNC;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            dtack_nxt = 1'b0;
            state_nxt = S_HOLD;
          end else begin
            wcnt_nxt = wcnt - 1'b1;
          end
        end
        S_VPA_SYNC: begin
          if (e_cnt == VMA_C) begin
            vma_nxt   = 1'b0;
            state_nxt = S_VPA_E;
          end
        end
        S_VPA_E: begin
          if (e_cnt == E_FALLM_C) begin
            dtack_nxt = 1'b0;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          dtack_nxt = 1'b0;
          if (e_cnt == E_FALL_C) vma_nxt = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign E_CLK       = e_clk_q;
  assign MB_VMA      = vma_q;
  assign CYCLE_DTACK = dtack_q;
  assign BUSY        = (state != S_IDLE);

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tcnt;
  logic          berr_q;
  logic          count_en;

  // Autovector (CPU space with /VPA) terminates without any DTACK.
  assign count_en = dtack_q & dtack_sync[1] & ~((CPU_FC == 3'b111) & ~vpa_s);

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      tcnt   <= '0;
      berr_q <= 1'b1;
    end else if (as_s) begin
      tcnt   <= '0;
      berr_q <= 1'b1;
    end else if (tcnt == TW'(TIMEOUT_CYC)) begin
      berr_q <= 1'b0;
    end else if (count_en) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign BERR_N = berr_q;
`else
  // MB_DTACK only feeds the timeout; keep it visibly consumed.
  logic unused_timeout;
  assign unused_timeout = dtack_sync[1] | (TIMEOUT_CYC < 0);
  assign BERR_N = 1'b1;
`endif

endmodule

// File: tb/tb_mb_cycle_sequencer.sv
module tb_mb_cycle_sequencer;

  localparam int E_DIV = 10, E_RISE = 4, E_FALL = 8, VMA_POINT = 2;
  localparam int NUM_CH = 3, WAIT_W = 4, TIMEOUT_CYC = 255;

  logic                     RESET, MB_CLK, CPU_AS, MB_VPA, MB_DTACK;
  logic [2:0]               CPU_FC;
  logic [NUM_CH-1:0]        CH_SEL;
  logic [NUM_CH*WAIT_W-1:0] CH_WAIT;
  logic                     E_CLK, MB_VMA, CYCLE_DTACK, BUSY, BERR_N;

  int n_assert = 0;
  int n_fail   = 0;
  int edges    = 0;

  mb_cycle_sequencer #(
    .E_DIV(E_DIV), .E_RISE(E_RISE), .E_FALL(E_FALL), .VMA_POINT(VMA_POINT),
    .NUM_CH(NUM_CH), .WAIT_W(WAIT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .RESET(RESET), .MB_CLK(MB_CLK), .CPU_AS(CPU_AS), .CPU_FC(CPU_FC),
    .MB_VPA(MB_VPA), .MB_DTACK(MB_DTACK), .CH_SEL(CH_SEL), .CH_WAIT(CH_WAIT),
    .E_CLK(E_CLK), .MB_VMA(MB_VMA), .CYCLE_DTACK(CYCLE_DTACK), .BUSY(BUSY),
    .BERR_N(BERR_N)
  );

  initial MB_CLK = 1'b0;
  always #5 MB_CLK = ~MB_CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (edge %0d): observed %b expected %b", tag, edges, obs, exp);
    end
  endtask

  // e_cnt value sampled on edge k (edges counted from 1 after reset release).
  function automatic int e_at(input int k);
    return (k - 1) % E_DIV;
  endfunction

  // E_CLK after edge k: set on the edge seeing E_RISE, cleared on E_FALL.
  function automatic logic e_high(input int k);
    return (e_at(k) >= E_RISE) && (e_at(k) < E_FALL);
  endfunction

  function automatic int next_edge(input int from, input int ev);
    int k = from;
    while (e_at(k) != ev) k++;
    return k;
  endfunction

  function automatic int pick_wait(input logic [NUM_CH-1:0] sel,
                                   input logic [NUM_CH*WAIT_W-1:0] w);
    for (int i = 0; i < NUM_CH; i++)
      if (sel[i]) return int'(w[i*WAIT_W +: WAIT_W]);
    return -1;
  endfunction

  task automatic tick();
    @(posedge MB_CLK);
    edges++;
    @(negedge MB_CLK);
    chk("e_clk", E_CLK, e_high(edges));
  endtask

  task automatic release_as();
    CPU_AS = 1'b1;
    MB_VPA = 1'b1;
    #1;
    chk("dtack_async_release", CYCLE_DTACK, 1'b1);
    chk("vma_async_release", MB_VMA, 1'b1);
    tick(); tick(); tick();
    chk("busy_after_release", BUSY, 1'b0);
    CH_SEL = '0;
  endtask

  // Channel cycle: DTACK on edge 2 sync + 1 decode + wait + 1 after /AS.
  task automatic run_chan(input logic [NUM_CH-1:0] sel,
                          input logic [NUM_CH*WAIT_W-1:0] w);
    int wt = pick_wait(sel, w);
    CH_SEL  = sel;
    CH_WAIT = w;
    CPU_AS  = 1'b0;
    for (int i = 1; i <= wt + 6; i++) begin
      tick();
      chk("chan_dtack", CYCLE_DTACK, (i >= wt + 4) ? 1'b0 : 1'b1);
      chk("chan_busy", BUSY, (i >= 3) ? 1'b1 : 1'b0);
      chk("chan_vma", MB_VMA, 1'b1);
    end
    release_as();
  endtask

  // 6800 cycle with /AS falling so that the first edge sees e_cnt == phase.
  task automatic run_vpa(input logic [2:0] fc, input int phase);
    int k0, dec, v0, d0, v1;
    logic cpu_space;
    while ((edges % E_DIV) != phase) tick();
    k0 = edges + 1;
    CPU_FC = fc;
    CPU_AS = 1'b0;
    MB_VPA = 1'b0;
    cpu_space = (fc == 3'b111);
    dec = k0 + 2;
    v0  = next_edge(dec + 1, VMA_POINT);
    d0  = next_edge(v0 + 1, E_FALL - 1);
    v1  = next_edge(d0 + 1, E_FALL);
    while (edges < v1 + 2) begin
      tick();
      chk("vpa_vma", MB_VMA, cpu_space ? 1'b1 : !(edges >= v0 && edges < v1));
      chk("vpa_dtack", CYCLE_DTACK, cpu_space ? 1'b1 : !(edges >= d0));
      chk("vpa_busy", BUSY, cpu_space ? 1'b0 : (edges >= dec));
    end
    release_as();
  endtask

  task automatic do_reset();
    RESET  = 1'b0;
    CPU_AS = 1'b1;
    MB_VPA = 1'b1;
    repeat (2) @(negedge MB_CLK);
    RESET = 1'b1;
    edges = 0;
  endtask

  initial begin
    int k0, v0;
    RESET = 1'b0; CPU_AS = 1'b1; CPU_FC = 3'b101; MB_VPA = 1'b1;
    MB_DTACK = 1'b1; CH_SEL = '0; CH_WAIT = '0;
    repeat (3) @(negedge MB_CLK);
    chk("rst_e_clk", E_CLK, 1'b0);
    chk("rst_vma", MB_VMA, 1'b1);
    chk("rst_dtack", CYCLE_DTACK, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_berr", BERR_N, 1'b1);
    RESET = 1'b1;
    edges = 0;

    // Free-running E clock.
    repeat (30) begin
      tick();
      chk("idle_vma", MB_VMA, 1'b1);
      chk("idle_dtack", CYCLE_DTACK, 1'b1);
    end

    // Directed channel cycles, including priority and all-ones wait.
    run_chan(3'b010, 12'h030);
    run_chan(3'b011, 12'h0F0);
    run_chan(3'b011, 12'h0FF);
    run_chan(3'b100, 12'hF00);

    // Directed 6800 cycles: /AS at e_cnt=5, normal and CPU space.
    run_vpa(3'b101, 5);
    run_vpa(3'b111, 5);
    // Late arrival that has to wait for the next period.
    run_vpa(3'b010, 2);

    // Abort in the middle of WAIT: no DTACK pulse.
    CH_SEL = 3'b001; CH_WAIT = 12'h00A; CPU_AS = 1'b0;
    repeat (5) tick();
    CPU_AS = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_dtack", CYCLE_DTACK, 1'b1);
      if (i >= 2) chk("abort_busy", BUSY, 1'b0);
    end
    CH_SEL = '0;
    run_chan(3'b001, 12'h005);

    // CH_SEL beats VPA.
    MB_VPA = 1'b0;
    run_chan(3'b100, 12'h200);

    // Randomised channel and VPA cycles.
    for (int n = 0; n < 12; n++)
      run_chan(NUM_CH'($urandom_range(1, 7)), NUM_CH*WAIT_W'($urandom));
    for (int n = 0; n < 5; n++)
      run_vpa(3'($urandom_range(0, 7)), $urandom_range(0, E_DIV - 1));

    // Reset while a 6800 cycle holds /VMA low.
    while ((edges % E_DIV) != 5) tick();
    k0 = edges + 1;
    CPU_FC = 3'b101; CPU_AS = 1'b0; MB_VPA = 1'b0;
    v0 = next_edge(k0 + 3, VMA_POINT);
    while (edges < v0 + 1) tick();
    chk("pre_reset_vma", MB_VMA, 1'b0);
    RESET = 1'b0;
    #1;
    chk("midrst_e_clk", E_CLK, 1'b0);
    chk("midrst_vma", MB_VMA, 1'b1);
    chk("midrst_dtack", CYCLE_DTACK, 1'b1);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_berr", BERR_N, 1'b1);
    do_reset();
    run_chan(3'b001, 12'h002);

    // No responder at all: timeout only with the optional feature.
    CPU_FC = 3'b101; CPU_AS = 1'b0;
`ifdef BUS_TIMEOUT_EN
    repeat (TIMEOUT_CYC + 6) tick();
    chk("timeout_berr", BERR_N, 1'b0);
    CPU_AS = 1'b1;
    repeat (3) tick();
    chk("timeout_berr_release", BERR_N, 1'b1);
`else
    repeat (40) begin
      tick();
      chk("no_timeout_berr", BERR_N, 1'b1);
      chk("no_responder_busy", BUSY, 1'b0);
    end
    CPU_AS = 1'b1;
    repeat (3) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
